armleocpu_cache_arbiter: RTL and testbench
==========================================

# armleocpu_cache_arbiter

Shares one cache command port between the fetch unit (instruction requester, port 0) and the execute/memory unit (data requester, port 1). It sits between both requesters and the cache, and forwards the granted requester's command with zero added latency. It holds the grant until the cache signals `c_done`, and grants round-robin so neither side starves. A sticky protocol-error flag records violations of the hold-until-done cache handshake.

## Interface
Parameters:
- `FETCH_PRIORITY`, default 0: when 1, port 0 always wins contention; when 0, contention is resolved round-robin.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_cmd` in 4: fetch command (`CACHE_CMD_*`).
- `f_address` in 32: fetch address.
- `f_done` out 1: cache done, routed to fetch.
- `f_response` out 4: cache response to fetch.
- `f_load_data` out 32: cache load data to fetch.
- `m_cmd` in 4: memory-unit command.
- `m_address` in 32: memory-unit address.
- `m_store_data` in 32: store data.
- `m_store_byteenable` in 4: store byte enables.
- `m_done` out 1: cache done, routed to the memory unit.
- `m_response` out 4: cache response to the memory unit.
- `m_load_data` out 32: cache load data to the memory unit.
- `c_cmd` out 4: command to the cache.
- `c_address` out 32: address to the cache.
- `c_store_data` out 32: store data to the cache.
- `c_store_byteenable` out 4: store byte enables to the cache.
- `c_done` in 1: cache done.
- `c_response` in 4: cache response.
- `c_load_data` in 32: cache load data.
- `protocol_error` out 1: sticky error flag.

## Operation
- Cache handshake:
  - A requester asserts cmd ≠ `CACHE_CMD_NONE` and holds cmd and address until it sees its done.
  - The cache asserts `c_done` for one cycle per command.
  - `c_done` is never asserted while no command is active.
- State machine, two states:
  - IDLE (no command outstanding at the cache).
  - BUSY(owner), where owner ∈ {F, M}.
- IDLE:
  - If only one requester has cmd ≠ NONE, grant it.
  - If both do, grant per `FETCH_PRIORITY` / round-robin pointer `last`: grant the port ≠ `last`.
  - The granted port's cmd, address and store data/byteenable drive `c_*` in the same cycle.
  - Register owner and move to BUSY; update `last` to the granted port.
  - If neither requests, `c_cmd` = NONE and all other `c_*` outputs are 0.
- BUSY(owner), `c_done`=0:
  - `c_*` follows the owner's inputs.
  - The other port's done stays 0.
- BUSY(owner), `c_done`=1:
  - Assert the owner's done for that cycle.
  - In the same cycle, re-arbitrate exactly as in IDLE, but with the owner's new cmd value. This permits back-to-back commands with no bubble.
  - If the result is NONE, go to IDLE.
- Response and load data: `c_response`/`c_load_data` are broadcast to both `*_response`/`*_load_data`. Only a port's done qualifies them.
- `protocol_error` sets (stays 1 until reset) when any of the following holds:
  - `c_done`=1 in IDLE.
  - In BUSY with `c_done`=0, the owner's cmd or address differs from the registered copy of the value issued.
- Flush commands (`CACHE_CMD_FLUSH_ALL`) from either port are arbitrated like any other command.

## Timing
- Reset values (asynchronous): state IDLE, `last`=M (so F wins the first contention), `protocol_error`=0, registered cmd/address copies = 0.
- In reset, `c_cmd`=NONE, `f_done`=`m_done`=0, and all other outputs are 0.
- Added latency is 0 cycles: request → `c_cmd` is combinational, and `c_done` → `*_done` is combinational.
- Combinational paths exist from `c_done`, `f_cmd` and `m_cmd` to `c_cmd`. Neither requester may derive its cmd from `c_cmd`.
- Simultaneous events:
  - A request from the non-owner during BUSY waits; its done stays 0 until it is granted and the cache completes.
  - On the done cycle, a waiting non-owner takes priority over an owner re-request when round-robin (`last`=owner).
- Reset asserted mid-command: the outstanding command is abandoned. The cache is assumed to be reset by the same `rst_n`.

## Test plan
- Single fetch: `f_cmd`=EXECUTE, `f_address`=0x1000, cache done after 3 cycles → `c_address`=0x1000 for all 3 cycles, `f_done`=1 on cycle 3, `m_done` stays 0.
- Contention after reset: both request in the same cycle → F granted first. On F's done, M is issued in the same cycle (`c_address`=M address), then F is granted on M's done.
- Back-to-back: fetch re-requests 0x1004 on the done cycle with M idle → `c_address`=0x1004 in that cycle, no NONE bubble.
- With `FETCH_PRIORITY`=1 and both requesting continuously → F granted every time, M never granted while F requests.
- Store path: `m_cmd`=STORE, `m_store_data`=0xDEADBEEF, byteenable 0x3 → `c_store_data`/`c_store_byteenable` match until `m_done`.
- Violations: `c_done`=1 in IDLE → `protocol_error`=1 and stays 1. The owner changing its address mid-BUSY also sets `protocol_error`. Asserting `rst_n`=0 mid-BUSY → `c_cmd`=NONE immediately and `protocol_error` clears.

Source files
------------

// File: rtl/armleocpu_cache_arbiter.sv
// armleocpu_cache_arbiter
//
// Shares one cache command port between the fetch unit (port F) and the
// memory/execute unit (port M). The granted requester's command is forwarded
// combinationally, so no latency is added. The grant is held until the cache
// reports c_done. Contention is resolved round-robin, or always in favour of
// fetch when FETCH_PRIORITY is 1. On a done cycle the arbiter re-arbitrates
// immediately, so back-to-back commands have no idle bubble. protocol_error
// is a sticky flag for violations of the hold-until-done handshake.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   f_cmd, f_address                  fetch request
//   f_done, f_response, f_load_data   cache completion routed to fetch
//   m_cmd, m_address, m_store_data,
//   m_store_byteenable                memory-unit request
//   m_done, m_response, m_load_data   cache completion routed to memory unit
//   c_cmd, c_address, c_store_data,
//   c_store_byteenable                command issued to the cache
//   c_done, c_response, c_load_data   cache completion
//   protocol_error                    sticky handshake-violation flag
module armleocpu_cache_arbiter #(
    parameter int FETCH_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  f_cmd,
    input  logic [31:0] f_address,
    output logic        f_done,
    output logic [3:0]  f_response,
    output logic [31:0] f_load_data,

    input  logic [3:0]  m_cmd,
    input  logic [31:0] m_address,
    input  logic [31:0] m_store_data,
    input  logic [3:0]  m_store_byteenable,
    output logic        m_done,
    output logic [3:0]  m_response,
    output logic [31:0] m_load_data,

    output logic [3:0]  c_cmd,
    output logic [31:0] c_address,
    output logic [31:0] c_store_data,
    output logic [3:0]  c_store_byteenable,
    input  logic        c_done,
    input  logic [3:0]  c_response,
    input  logic [31:0] c_load_data,

    output logic        protocol_error
);

    localparam logic [3:0] CACHE_CMD_NONE = 4'd0;
    localparam logic       PORT_F = 1'b0;
    localparam logic       PORT_M = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_next;
    logic        owner, owner_next;
    logic        last, last_next;
    logic        error, error_next;
    logic [3:0]  issued_cmd, issued_cmd_next;
    logic [31:0] issued_address, issued_address_next;

    logic        f_req, m_req;
    logic        grant_valid, grant_port;
    logic        arbitrate;
    logic        sel_valid, sel_port;
    logic [3:0]  owner_cmd;
    logic [31:0] owner_address;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= PORT_F;
            last           <= PORT_M;
            error          <= 1'b0;
            issued_cmd     <= CACHE_CMD_NONE;
            issued_address <= 32'd0;
        end else begin
            state          <= state_next;
            owner          <= owner_next;
            last           <= last_next;
            error          <= error_next;
            issued_cmd     <= issued_cmd_next;
            issued_address <= issued_address_next;
        end
    end

    always_comb begin
        state_next          = state;
        owner_next          = owner;
        last_next           = last;
        error_next          = error;
        issued_cmd_next     = issued_cmd;
        issued_address_next = issued_address;

        f_req = (f_cmd != CACHE_CMD_NONE);
        m_req = (m_cmd != CACHE_CMD_NONE);

        // Under contention the port that was not granted last time wins,
        // unless fetch has fixed priority.
        grant_valid = f_req || m_req;
        if (f_req && m_req)
            grant_port = (FETCH_PRIORITY != 0) ? PORT_F : ~last;
        else
            grant_port = m_req;

        // A done cycle frees the cache, so it is arbitrated like IDLE.
        arbitrate = (state == IDLE) || c_done;
        sel_valid = rst_n && (arbitrate ? grant_valid : 1'b1);
        sel_port  = arbitrate ? grant_port : owner;

        owner_cmd     = (owner == PORT_M) ? m_cmd : f_cmd;
        owner_address = (owner == PORT_M) ? m_address : f_address;

        c_cmd              = CACHE_CMD_NONE;
        c_address          = 32'd0;
        c_store_data       = 32'd0;
        c_store_byteenable = 4'd0;
        if (sel_valid) begin
            if (sel_port == PORT_M) begin
                c_cmd              = m_cmd;
                c_address          = m_address;
                c_store_data       = m_store_data;
                c_store_byteenable = m_store_byteenable;
            end else begin
                c_cmd     = f_cmd;
                c_address = f_address;
            end
        end

        f_done      = rst_n && (state == BUSY) && c_done && (owner == PORT_F);
        m_done      = rst_n && (state == BUSY) && c_done && (owner == PORT_M);
        f_response  = rst_n ? c_response : 4'd0;
        m_response  = rst_n ? c_response : 4'd0;
        f_load_data = rst_n ? c_load_data : 32'd0;
        m_load_data = rst_n ? c_load_data : 32'd0;

        // The owner must hold exactly what was issued until its done.
        if (state == IDLE && c_done)
            error_next = 1'b1;
        if (state == BUSY && !c_done &&
            (owner_cmd != issued_cmd || owner_address != issued_address))
            error_next = 1'b1;

        if (arbitrate) begin
            if (grant_valid) begin
                state_next          = BUSY;
                owner_next          = grant_port;
                last_next           = grant_port;
                issued_cmd_next     = (grant_port == PORT_M) ? m_cmd : f_cmd;
                issued_address_next = (grant_port == PORT_M) ? m_address : f_address;
            end else begin
                state_next = IDLE;
            end
        end
    end

    assign protocol_error = error;

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// Testbench for armleocpu_cache_arbiter: directed handshake scenarios,
// a fixed-priority instance, and a randomized run against a transaction-level
// model of which requester the cache is serving.
module tb_armleocpu_cache_arbiter;

    localparam logic [3:0] CMD_NONE      = 4'd0;
    localparam logic [3:0] CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CMD_LOAD      = 4'd2;
    localparam logic [3:0] CMD_STORE     = 4'd3;
    localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  f_cmd;
    logic [31:0] f_address;
    logic [3:0]  m_cmd;
    logic [31:0] m_address;
    logic [31:0] m_store_data;
    logic [3:0]  m_store_byteenable;
    logic        c_done;
    logic        c_done_fp;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;

    logic        f_done, m_done, protocol_error;
    logic [3:0]  f_response, m_response, c_cmd, c_store_byteenable;
    logic [31:0] f_load_data, m_load_data, c_address, c_store_data;

    logic        f_done_fp, m_done_fp, protocol_error_fp;
    logic [3:0]  f_response_fp, m_response_fp, c_cmd_fp, c_store_byteenable_fp;
    logic [31:0] f_load_data_fp, m_load_data_fp, c_address_fp, c_store_data_fp;

    int n_tests = 0;
    int n_fail  = 0;

    armleocpu_cache_arbiter #(.FETCH_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_cmd(f_cmd), .f_address(f_address),
        .f_done(f_done), .f_response(f_response), .f_load_data(f_load_data),
        .m_cmd(m_cmd), .m_address(m_address),
        .m_store_data(m_store_data), .m_store_byteenable(m_store_byteenable),
        .m_done(m_done), .m_response(m_response), .m_load_data(m_load_data),
        .c_cmd(c_cmd), .c_address(c_address),
        .c_store_data(c_store_data), .c_store_byteenable(c_store_byteenable),
        .c_done(c_done), .c_response(c_response), .c_load_data(c_load_data),
        .protocol_error(protocol_error)
    );

    armleocpu_cache_arbiter #(.FETCH_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .f_cmd(f_cmd), .f_address(f_address),
        .f_done(f_done_fp), .f_response(f_response_fp), .f_load_data(f_load_data_fp),
        .m_cmd(m_cmd), .m_address(m_address),
        .m_store_data(m_store_data), .m_store_byteenable(m_store_byteenable),
        .m_done(m_done_fp), .m_response(m_response_fp), .m_load_data(m_load_data_fp),
        .c_cmd(c_cmd_fp), .c_address(c_address_fp),
        .c_store_data(c_store_data_fp), .c_store_byteenable(c_store_byteenable_fp),
        .c_done(c_done_fp), .c_response(c_response), .c_load_data(c_load_data),
        .protocol_error(protocol_error_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic at_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_cmd = CMD_NONE;  f_address = 32'd0;
        m_cmd = CMD_NONE;  m_address = 32'd0;
        m_store_data = 32'd0; m_store_byteenable = 4'd0;
        c_done = 1'b0; c_done_fp = 1'b0;
    endtask

    task automatic do_reset();
        at_cycle();
        rst_n = 1'b0;
        idle_inputs();
        at_cycle();
        rst_n = 1'b1;
    endtask

    // Reference model: who the cache is currently serving (-1 = nobody),
    // which port was served most recently, what was issued, and the error flag.
    int          owner_m;
    int          last_m;
    bit          err_m;
    logic [3:0]  iss_cmd;
    logic [31:0] iss_addr;
    bit          f_hold, m_hold;
    bit          cache_busy;
    int          cache_cnt;

    function automatic int pick(input bit fr, input bit mr, input int lst);
        if (fr && mr) return (lst == 0) ? 1 : 0;
        if (fr) return 0;
        if (mr) return 1;
        return -1;
    endfunction

    task automatic start_f();
        f_cmd     = ($urandom_range(0, 5) == 0) ? CMD_FLUSH_ALL : CMD_EXECUTE;
        f_address = $urandom & 32'hFFFF_FFFC;
        f_hold    = 1'b1;
    endtask

    task automatic start_m();
        case ($urandom_range(0, 3))
            0:       m_cmd = CMD_LOAD;
            1:       m_cmd = CMD_FLUSH_ALL;
            default: m_cmd = CMD_STORE;
        endcase
        m_address          = $urandom;
        m_store_data       = $urandom;
        m_store_byteenable = 4'($urandom);
        m_hold             = 1'b1;
    endtask

    initial begin
        int          w;
        logic [3:0]  exp_cmd;
        logic [31:0] exp_addr;
        logic [31:0] fa;

        rst_n = 1'b0;
        idle_inputs();
        c_response = 4'd0;
        c_load_data = 32'd0;

        // Reset state, even with a request pending.
        f_cmd = CMD_EXECUTE; f_address = 32'h1000;
        c_response = 4'hA; c_load_data = 32'h1234_5678;
        #3;
        check("rst_c_cmd", 32'(c_cmd), 32'(CMD_NONE));
        check("rst_c_address", c_address, 32'd0);
        check("rst_dones", 32'({f_done, m_done}), 32'd0);
        check("rst_perr", 32'(protocol_error), 32'd0);
        check("rst_load_data", f_load_data | m_load_data, 32'd0);
        idle_inputs();
        c_response = 4'd0; c_load_data = 32'd0;
        at_cycle();
        rst_n = 1'b1;

        // Single fetch, done on the third cycle, then a back-to-back re-request.
        at_cycle();
        f_cmd = CMD_EXECUTE; f_address = 32'h1000;
        #2;
        check("sf_c1_addr", c_address, 32'h1000);
        check("sf_c1_cmd", 32'(c_cmd), 32'(CMD_EXECUTE));
        check("sf_c1_fdone", 32'(f_done), 32'd0);
        at_cycle(); #2;
        check("sf_c2_addr", c_address, 32'h1000);
        at_cycle();
        c_done = 1'b1;
        c_response = 4'h5; c_load_data = 32'hCAFE_0001;
        #2;
        check("sf_c3_addr", c_address, 32'h1000);
        check("sf_c3_fdone", 32'(f_done), 32'd1);
        check("sf_c3_mdone", 32'(m_done), 32'd0);
        check("sf_c3_fresp", 32'(f_response), 32'h5);
        check("sf_c3_fdata", f_load_data, 32'hCAFE_0001);
        f_address = 32'h1004;
        #1;
        check("b2b_addr", c_address, 32'h1004);
        check("b2b_cmd", 32'(c_cmd), 32'(CMD_EXECUTE));
        at_cycle();
        c_done = 1'b0;
        #2;
        check("b2b_hold_addr", c_address, 32'h1004);
        check("b2b_perr", 32'(protocol_error), 32'd0);
        at_cycle();
        c_done = 1'b1; f_cmd = CMD_NONE; f_address = 32'd0;
        #2;
        check("b2b_fdone", 32'(f_done), 32'd1);
        check("b2b_end_cmd", 32'(c_cmd), 32'(CMD_NONE));
        at_cycle();
        c_done = 1'b0;
        #2;
        check("idle_cmd", 32'(c_cmd), 32'(CMD_NONE));
        check("idle_perr", 32'(protocol_error), 32'd0);

        // Contention right after reset: F first, then M on F's done, then F.
        do_reset();
        at_cycle();
        f_cmd = CMD_EXECUTE; f_address = 32'h2000;
        m_cmd = CMD_LOAD;    m_address = 32'h3000;
        #2;
        check("ct_first_addr", c_address, 32'h2000);
        check("ct_first_mdone", 32'(m_done), 32'd0);
        at_cycle();
        c_done = 1'b1;
        #1;
        f_address = 32'h2004;
        #1;
        check("ct_fdone", 32'(f_done), 32'd1);
        check("ct_mdone0", 32'(m_done), 32'd0);
        check("ct_m_issued_addr", c_address, 32'h3000);
        check("ct_m_issued_cmd", 32'(c_cmd), 32'(CMD_LOAD));
        at_cycle();
        c_done = 1'b0;
        #2;
        check("ct_m_hold", c_address, 32'h3000);
        check("ct_fwait_done", 32'(f_done), 32'd0);
        at_cycle();
        c_done = 1'b1;
        #1;
        m_cmd = CMD_NONE;
        #1;
        check("ct_mdone", 32'(m_done), 32'd1);
        check("ct_f_regrant", c_address, 32'h2004);
        at_cycle();
        f_cmd = CMD_NONE;
        #2;
        check("ct_f_last_done", 32'(f_done), 32'd1);
        check("ct_none", 32'(c_cmd), 32'(CMD_NONE));
        at_cycle();
        c_done = 1'b0;

        // Store path.
        at_cycle();
        m_cmd = CMD_STORE; m_address = 32'h4000;
        m_store_data = 32'hDEAD_BEEF; m_store_byteenable = 4'h3;
        #2;
        check("st_data", c_store_data, 32'hDEAD_BEEF);
        check("st_be", 32'(c_store_byteenable), 32'h3);
        check("st_cmd", 32'(c_cmd), 32'(CMD_STORE));
        at_cycle(); #2;
        check("st_data_hold", c_store_data, 32'hDEAD_BEEF);
        at_cycle();
        c_done = 1'b1;
        #2;
        check("st_mdone", 32'(m_done), 32'd1);
        check("st_data_done", c_store_data, 32'hDEAD_BEEF);
        m_cmd = CMD_NONE;
        #1;
        check("st_after_data", c_store_data, 32'd0);
        check("st_after_be", 32'(c_store_byteenable), 32'd0);
        at_cycle();
        c_done = 1'b0;
        #2;
        check("st_perr", 32'(protocol_error), 32'd0);

        // Violation: done while idle, flag is sticky.
        at_cycle();
        c_done = 1'b1;
        #2;
        check("v_idle_dones", 32'({f_done, m_done}), 32'd0);
        at_cycle();
        c_done = 1'b0;
        #2;
        check("v_idle_perr", 32'(protocol_error), 32'd1);
        at_cycle(); at_cycle(); #2;
        check("v_idle_sticky", 32'(protocol_error), 32'd1);

        // Violation: owner changes address mid-command.
        do_reset();
        #2;
        check("v_reset_clear", 32'(protocol_error), 32'd0);
        at_cycle();
        m_cmd = CMD_LOAD; m_address = 32'h5000;
        at_cycle();
        m_address = 32'h5004;
        at_cycle(); #2;
        check("v_addr_perr", 32'(protocol_error), 32'd1);

        // Reset mid-command: output drops at once and the flag clears.
        at_cycle();
        rst_n = 1'b0;
        #1;
        check("rmid_cmd", 32'(c_cmd), 32'(CMD_NONE));
        check("rmid_perr", 32'(protocol_error), 32'd0);
        check("rmid_addr", c_address, 32'd0);
        idle_inputs();
        at_cycle();
        rst_n = 1'b1;

        // Fixed fetch priority: fetch wins every done cycle while it requests.
        do_reset();
        at_cycle();
        fa = 32'h8000;
        f_cmd = CMD_EXECUTE; f_address = fa;
        m_cmd = CMD_LOAD;    m_address = 32'h9000;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("fp_hold_addr", c_address_fp, fa);
            check("fp_hold_mdone", 32'(m_done_fp), 32'd0);
            at_cycle();
            c_done_fp = 1'b1;
            #1;
            check("fp_fdone", 32'(f_done_fp), 32'd1);
            fa = fa + 32'd4;
            f_address = fa;
            #1;
            check("fp_regrant_f", c_address_fp, fa);
            check("fp_regrant_cmd", 32'(c_cmd_fp), 32'(CMD_EXECUTE));
            at_cycle();
            c_done_fp = 1'b0;
        end
        at_cycle();
        c_done_fp = 1'b1;
        #1;
        f_cmd = CMD_NONE;
        #1;
        check("fp_m_finally", c_address_fp, 32'h9000);
        at_cycle();
        c_done_fp = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        owner_m = -1; last_m = 1; err_m = 1'b0;
        iss_cmd = CMD_NONE; iss_addr = 32'd0;
        f_hold = 1'b0; m_hold = 1'b0;
        cache_busy = 1'b0; cache_cnt = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            at_cycle();
            c_done      = cache_busy && (cache_cnt == 0);
            c_response  = 4'($urandom);
            c_load_data = $urandom;
            if (!f_hold && $urandom_range(0, 2) == 0) start_f();
            if (!m_hold && $urandom_range(0, 2) == 0) start_m();
            #1;
            if (f_done) begin
                f_hold = 1'b0;
                if ($urandom_range(0, 1) == 1) start_f();
                else f_cmd = CMD_NONE;
            end
            if (m_done) begin
                m_hold = 1'b0;
                if ($urandom_range(0, 1) == 1) start_m();
                else m_cmd = CMD_NONE;
            end
            #1;
            w = (owner_m < 0 || c_done) ? pick(f_cmd != CMD_NONE, m_cmd != CMD_NONE, last_m)
                                        : owner_m;
            exp_cmd  = (w == 0) ? f_cmd : (w == 1) ? m_cmd : CMD_NONE;
            exp_addr = (w == 0) ? f_address : (w == 1) ? m_address : 32'd0;
            check("rnd_c_cmd", 32'(c_cmd), 32'(exp_cmd));
            check("rnd_c_address", c_address, exp_addr);
            check("rnd_c_store_data", c_store_data, (w == 1) ? m_store_data : 32'd0);
            check("rnd_c_be", 32'(c_store_byteenable),
                  (w == 1) ? 32'(m_store_byteenable) : 32'd0);
            check("rnd_f_done", 32'(f_done), 32'(c_done && owner_m == 0));
            check("rnd_m_done", 32'(m_done), 32'(c_done && owner_m == 1));
            check("rnd_resp", 32'({f_response, m_response}), 32'({c_response, c_response}));
            check("rnd_load_data", f_load_data ^ m_load_data, 32'd0);
            check("rnd_perr", 32'(protocol_error), 32'(err_m));

            if (owner_m < 0 && c_done) err_m = 1'b1;
            if (owner_m >= 0 && !c_done &&
                (((owner_m == 0) ? f_cmd : m_cmd) != iss_cmd ||
                 ((owner_m == 0) ? f_address : m_address) != iss_addr))
                err_m = 1'b1;
            if (owner_m < 0 || c_done) begin
                owner_m = w;
                if (w >= 0) begin
                    last_m   = w;
                    iss_cmd  = exp_cmd;
                    iss_addr = exp_addr;
                end
            end

            if (c_cmd != CMD_NONE) begin
                if (!cache_busy || c_done) begin
                    cache_busy = 1'b1;
                    cache_cnt  = $urandom_range(0, 3);
                end else if (cache_cnt > 0) begin
                    cache_cnt = cache_cnt - 1;
                end
            end else begin
                cache_busy = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
